// File: rtl/pos_cache_motion_update_arbiter_pkg.sv
// Shared definitions for the Pos_Cache motion-update arbiter slice.
// Contents:
//   POS_* localparams  default widths and sizes used by the interface and the top
//   arb_state_t        pass sequencing states
//   dst_cell_t         {x,y,z} destination cell as carried on the broadcast bus
//   pack_dst_cell      builds the {x,y,z} destination word from per-axis IDs
package pos_cache_motion_update_arbiter_pkg;

    localparam int POS_NUM_SRC        = 4;
    localparam int POS_DATA_WIDTH     = 96;
    localparam int POS_CELL_ID_WIDTH  = 4;
    localparam int POS_DST_WIDTH      = 3 * POS_CELL_ID_WIDTH;
    localparam int POS_SWAP_CYCLES    = 3;
    localparam int POS_COUNT_WIDTH    = 16;
    localparam int POS_PARTICLE_TOTAL = 20000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_DRAIN,
        ST_SWAP,
        ST_FINISH
    } arb_state_t;

    typedef struct packed {
        logic [POS_CELL_ID_WIDTH-1:0] x;
        logic [POS_CELL_ID_WIDTH-1:0] y;
        logic [POS_CELL_ID_WIDTH-1:0] z;
    } dst_cell_t;

    function automatic logic [POS_DST_WIDTH-1:0] pack_dst_cell(
        input logic [POS_CELL_ID_WIDTH-1:0] x,
        input logic [POS_CELL_ID_WIDTH-1:0] y,
        input logic [POS_CELL_ID_WIDTH-1:0] z
    );
        dst_cell_t c;
        c.x = x;
        c.y = y;
        c.z = z;
        return c;
    endfunction

endpackage

// File: rtl/pos_cache_motion_update_arbiter_if.sv
// Bus bundle between the motion-update engines, the arbiter and the cache broadcast bus.
// Signals:
//   start                 begin a pass (pulse)
//   src_req/src_data/src_dst_cell/src_done   per-engine request side, slice i = engine i
//   src_grant             one-hot grant back to the engines
//   motion_update_enable  cache enable
//   out_data/out_data_dst_cell/out_data_valid  broadcast bus to every cache cell
//   busy/done/broadcast_count/count_mismatch   pass status
// Modports: master = arbiter, slave = engines/caches/environment.
interface pos_cache_motion_update_arbiter_if
    import pos_cache_motion_update_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = POS_NUM_SRC,
    parameter int DATA_WIDTH    = POS_DATA_WIDTH,
    parameter int CELL_ID_WIDTH = POS_CELL_ID_WIDTH,
    parameter int COUNT_WIDTH   = POS_COUNT_WIDTH
);

    logic                                 start;
    logic [NUM_SRC-1:0]                   src_req;
    logic [NUM_SRC*DATA_WIDTH-1:0]        src_data;
    logic [NUM_SRC*3*CELL_ID_WIDTH-1:0]   src_dst_cell;
    logic [NUM_SRC-1:0]                   src_done;
    logic [NUM_SRC-1:0]                   src_grant;
    logic                                 motion_update_enable;
    logic [DATA_WIDTH-1:0]                out_data;
    logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell;
    logic                                 out_data_valid;
    logic                                 busy;
    logic                                 done;
    logic [COUNT_WIDTH-1:0]               broadcast_count;
    logic                                 count_mismatch;

    modport master (
        input  start, src_req, src_data, src_dst_cell, src_done,
        output src_grant, motion_update_enable, out_data, out_data_dst_cell,
               out_data_valid, busy, done, broadcast_count, count_mismatch
    );

    modport slave (
        output start, src_req, src_data, src_dst_cell, src_done,
        input  src_grant, motion_update_enable, out_data, out_data_dst_cell,
               out_data_valid, busy, done, broadcast_count, count_mismatch
    );

endinterface

// File: rtl/pos_cache_motion_update_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        in   NUM_SRC     request vector (already masked by the caller)
//   ptr        in   IDX_WIDTH   highest-priority index this cycle
//   grant      out  NUM_SRC     one-hot grant, zero when nothing requests
//   grant_idx  out  IDX_WIDTH   index of the granted bit
//   grant_valid out 1           some request was granted
module rr_arbiter
    import pos_cache_motion_update_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = POS_NUM_SRC,
    parameter int IDX_WIDTH = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_SRC-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    // Scan starting at ptr and wrap; the first requester found wins.
    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            if (!grant_valid && req[IDX_WIDTH'(j)]) begin
                grant[IDX_WIDTH'(j)] = 1'b1;
                grant_idx            = IDX_WIDTH'(j);
                grant_valid          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pos_cache_motion_update_arbiter.sv
// Sequences one motion-update pass over all Pos_Cache cells: round-robin arbitrates the
// motion-update engines onto the shared broadcast bus, holds motion_update_enable while
// words flow, then drops it long enough for every cache to swap buffers and pulses done.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous reset, active-high
//   bus   master modport of pos_cache_motion_update_arbiter_if (engine side, broadcast
//         bus and pass status)
module pos_cache_motion_update_arbiter
    import pos_cache_motion_update_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = POS_NUM_SRC,
    parameter int DATA_WIDTH     = POS_DATA_WIDTH,
    parameter int CELL_ID_WIDTH  = POS_CELL_ID_WIDTH,
    parameter int SWAP_CYCLES    = POS_SWAP_CYCLES,
    parameter int COUNT_WIDTH    = POS_COUNT_WIDTH,
    parameter int PARTICLE_TOTAL = POS_PARTICLE_TOTAL
) (
    input  logic clk,
    input  logic rst,
    pos_cache_motion_update_arbiter_if.master bus
);

    localparam int DST_WIDTH = 3 * CELL_ID_WIDTH;
    localparam int IDX_WIDTH = $clog2(NUM_SRC);
    localparam int SWAP_CW   = $clog2(SWAP_CYCLES + 1);

    arb_state_t             state;
    logic [IDX_WIDTH-1:0]   rr_ptr;
    logic [NUM_SRC-1:0]     done_latch;
    logic [SWAP_CW-1:0]     swap_cnt;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   enable_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [DST_WIDTH-1:0]   out_dst_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   mismatch_q;

    logic [NUM_SRC-1:0]     masked_req;
    logic [NUM_SRC-1:0]     arb_grant;
    logic [IDX_WIDTH-1:0]   arb_idx;
    logic                   arb_valid;
    logic                   all_done;

    // A request raised together with src_done still competes; only latched engines are masked.
    assign masked_req = bus.src_req & ~done_latch;
    assign all_done   = &(done_latch | bus.src_done);

    rr_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req         (masked_req),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign bus.src_grant            = (state == ST_BCAST) ? arb_grant : '0;
    assign bus.motion_update_enable = enable_q;
    assign bus.out_data             = out_data_q;
    assign bus.out_data_dst_cell    = out_dst_q;
    assign bus.out_data_valid       = out_valid_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.broadcast_count      = count_q;
    assign bus.count_mismatch       = mismatch_q;

    // Pass FSM with registered outputs. The broadcast registers default to idle every
    // cycle so only a granted cycle puts a word on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            done_latch  <= '0;
            swap_cnt    <= '0;
            count_q     <= '0;
            enable_q    <= 1'b0;
            out_data_q  <= '0;
            out_dst_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dst_q   <= '0;
            done_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_BCAST;
                        enable_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        count_q    <= '0;
                        done_latch <= '0;
                    end
                end
                ST_BCAST: begin
                    done_latch <= done_latch | bus.src_done;
                    if (arb_valid) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.src_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                        out_dst_q   <= bus.src_dst_cell[arb_idx*DST_WIDTH +: DST_WIDTH];
                        if (count_q != '1) begin
                            count_q <= count_q + COUNT_WIDTH'(1);
                        end
                        rr_ptr <= (arb_idx == IDX_WIDTH'(NUM_SRC - 1)) ? '0
                                                                      : arb_idx + IDX_WIDTH'(1);
                    end else if (all_done) begin
                        state <= ST_DRAIN;
                    end
                end
                // One extra enabled cycle so the caches capture the last broadcast word.
                ST_DRAIN: begin
                    state    <= ST_SWAP;
                    enable_q <= 1'b0;
                    swap_cnt <= '0;
                end
                ST_SWAP: begin
                    if (swap_cnt == SWAP_CW'(SWAP_CYCLES - 1)) begin
                        state  <= ST_FINISH;
                        done_q <= 1'b1;
                    end else begin
                        swap_cnt <= swap_cnt + SWAP_CW'(1);
                    end
                end
                ST_FINISH: begin
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    mismatch_q <= mismatch_q | (count_q != COUNT_WIDTH'(PARTICLE_TOTAL));
                end
                default: begin
                    state    <= ST_IDLE;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pos_cache_motion_update_arbiter.sv
// Self-checking bench for pos_cache_motion_update_arbiter. Engines are modelled as
// per-engine word counters; every predicted grant pushes the expected broadcast word
// onto a scoreboard queue, which is popped when the registered bus word appears.
module tb_pos_cache_motion_update_arbiter;
    import pos_cache_motion_update_arbiter_pkg::*;

    localparam int NS     = 4;
    localparam int DW     = 96;
    localparam int CW     = 4;
    localparam int DSTW   = 3 * CW;
    localparam int SW     = 3;
    localparam int COUNTW = 16;
    localparam int PT     = 12;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DSTW-1:0] dst;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    pos_cache_motion_update_arbiter_if #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .COUNT_WIDTH(COUNTW)
    ) bus ();

    pos_cache_motion_update_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .SWAP_CYCLES(SW),
        .COUNT_WIDTH(COUNTW), .PARTICLE_TOTAL(PT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            checks = 0;
    int            errors = 0;
    int            remaining[NS];
    int            sent[NS];
    bit            done_mode[NS];
    bit            stray_req[NS];
    int            pass_id = 0;
    int            m_ptr = 0;
    bit            m_bcast = 1'b0;
    bit            m_mismatch = 1'b0;
    logic [NS-1:0] m_latch = '0;
    word_t         sb[$];
    int            popped = 0;
    int            first_grant = -1;

    function automatic logic [DW-1:0] word_of(input int e, input int n);
        return {32'(e + 1), 32'(n), 32'hC0DE_0000 | 32'(pass_id)};
    endfunction

    function automatic logic [DSTW-1:0] dst_of(input int e, input int n);
        return pack_dst_cell(CW'(e + 1), CW'(n), CW'(pass_id));
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setEngines(input int r0, input int r1, input int r2, input int r3);
        remaining[0] = r0;
        remaining[1] = r1;
        remaining[2] = r2;
        remaining[3] = r3;
        for (int e = 0; e < NS; e++) begin
            sent[e]      = 0;
            done_mode[e] = 1'b0;
            stray_req[e] = 1'b0;
        end
        pass_id++;
    endtask

    // Engines request while words remain; done is a level, either after or with the last word.
    task automatic applyStimulus();
        for (int e = 0; e < NS; e++) begin
            bus.src_req[e]                     = (remaining[e] > 0) || stray_req[e];
            bus.src_data[e*DW +: DW]           = word_of(e, sent[e]);
            bus.src_dst_cell[e*DSTW +: DSTW]   = dst_of(e, sent[e]);
            bus.src_done[e] = done_mode[e] ? (remaining[e] <= 1) : (remaining[e] == 0);
        end
    endtask

    // One BCAST cycle: predict the grant, push the expected word, compare the registered word.
    task automatic step();
        logic [NS-1:0] masked;
        logic [NS-1:0] exp_grant;
        int            g;
        bit            pushed;
        word_t         w;
        @(negedge clk);
        masked    = bus.src_req & ~m_latch;
        exp_grant = '0;
        g         = -1;
        pushed    = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (g < 0 && masked[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
        end
        checkOutput("enable_bcast", bus.motion_update_enable, 1);
        checkOutput("busy_bcast", bus.busy, 1);
        if (g >= 0) begin
            exp_grant[g] = 1'b1;
            w.data = word_of(g, sent[g]);
            w.dst  = dst_of(g, sent[g]);
            sb.push_back(w);
            sent[g]++;
            remaining[g]--;
            m_ptr  = (g + 1) % NS;
            pushed = 1'b1;
            if (first_grant < 0) first_grant = cycle;
        end else if (&(m_latch | bus.src_done)) begin
            m_bcast = 1'b0;
        end
        checkOutput("grant", bus.src_grant, exp_grant);
        m_latch = m_latch | bus.src_done;
        @(posedge clk);
        #1;
        checkOutput("out_valid", bus.out_data_valid, pushed);
        if (pushed) begin
            w = sb.pop_front();
            popped++;
            checkOutput("out_data", bus.out_data, w.data);
            checkOutput("out_dst", bus.out_data_dst_cell, w.dst);
        end else begin
            checkOutput("out_data_idle", bus.out_data, 0);
        end
        applyStimulus();
    endtask

    task automatic run_pass(input int exp_count, input bit inject_start);
        int guard;
        bit seen;
        int done_cycle;
        popped      = 0;
        first_grant = -1;
        m_latch     = '0;
        m_bcast     = 1'b1;
        applyStimulus();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_start", bus.busy, 1);
        checkOutput("enable_start", bus.motion_update_enable, 1);
        checkOutput("count_cleared", bus.broadcast_count, 0);
        guard = 0;
        while (m_bcast && guard < 200) begin
            if (inject_start && guard == 2) bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            guard++;
        end
        @(negedge clk);
        checkOutput("enable_drain", bus.motion_update_enable, 1);
        checkOutput("grant_drain", bus.src_grant, 0);
        seen       = 1'b0;
        done_cycle = -1;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (inject_start && i == 2) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen       = 1'b1;
                done_cycle = cycle;
            end else if (i == 1) begin
                checkOutput("enable_swap", bus.motion_update_enable, 0);
            end
        end
        checkOutput("done_seen", seen, 1);
        if (seen) checkOutput("done_latency", done_cycle - first_grant, exp_count + 5);
        checkOutput("words_broadcast", popped, exp_count);
        checkOutput("count", bus.broadcast_count, exp_count);
        m_mismatch = m_mismatch | (exp_count != PT);
        @(posedge clk);
        #1;
        checkOutput("done_pulse", bus.done, 0);
        checkOutput("busy_idle", bus.busy, 0);
        checkOutput("enable_idle", bus.motion_update_enable, 0);
        checkOutput("mismatch", bus.count_mismatch, m_mismatch);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("count_hold", bus.broadcast_count, exp_count);
        checkOutput("still_idle", bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start        = 1'b0;
        bus.src_req      = '0;
        bus.src_data     = '0;
        bus.src_dst_cell = '0;
        bus.src_done     = '0;
        rst              = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, with requests already pending while idle.
        setEngines(3, 3, 3, 3);
        applyStimulus();
        @(negedge clk);
        checkOutput("rst_grant", bus.src_grant, 0);
        checkOutput("rst_enable", bus.motion_update_enable, 0);
        checkOutput("rst_valid", bus.out_data_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_count", bus.broadcast_count, 0);
        checkOutput("rst_mismatch", bus.count_mismatch, 0);
        @(posedge clk);
        #1;

        $display("[TB] all engines, three words each");
        run_pass(12, 1'b0);

        $display("[TB] eleven words with stray start pulses");
        setEngines(3, 3, 3, 2);
        run_pass(11, 1'b1);

        $display("[TB] engine 2 alone, five words");
        setEngines(0, 0, 5, 0);
        run_pass(5, 1'b0);

        $display("[TB] engine 1 done with last word, then stray request");
        setEngines(0, 3, 0, 0);
        done_mode[1] = 1'b1;
        stray_req[1] = 1'b1;
        run_pass(3, 1'b0);
        stray_req[1] = 1'b0;

        $display("[TB] reset in the middle of a pass");
        setEngines(3, 3, 3, 3);
        m_latch = '0;
        m_bcast = 1'b1;
        applyStimulus();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_enable", bus.motion_update_enable, 0);
        checkOutput("midrst_valid", bus.out_data_valid, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_grant", bus.src_grant, 0);
        checkOutput("midrst_count", bus.broadcast_count, 0);
        checkOutput("midrst_mismatch", bus.count_mismatch, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        m_ptr      = 0;
        m_mismatch = 1'b0;
        sb.delete();
        setEngines(3, 3, 3, 3);
        run_pass(12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
